// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler
// Shares one pump among four irrigation zones. Requests are latched per zone,
// granted one at a time in round-robin order, run for a short or long number
// of one-second ticks, and each run is followed by a pump-off settle gap.
module irrigation_zone_scheduler #(
    parameter int TICK_DIV  = 50000000,
    parameter int RUN_SHORT = 30,
    parameter int RUN_LONG  = 60,
    parameter int GAP_S     = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] long_sel,
    input  logic       abort,
    output logic [3:0] valve,
    output logic       pump_on,
    output logic [1:0] grant_id,
    output logic [5:0] remaining,
    output logic       busy,
    output logic       done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_S + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [5:0]    LEN_SHORT = 6'(RUN_SHORT);
    localparam logic [5:0]    LEN_LONG  = 6'(RUN_LONG);
    localparam logic [GW-1:0] GAP_LEN   = GW'(GAP_S);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    dur_q, dur_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    valve_q, valve_d;
    logic [1:0]    gid_q, gid_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          pump_q, pump_d;

    logic          tick;
    logic          found;
    logic [1:0]    pick;
    logic [1:0]    cand;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            dur_q     <= '0;
            rr_ptr_q  <= '0;
            pre_q     <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            valve_q   <= '0;
            gid_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            pump_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dur_q     <= dur_d;
            rr_ptr_q  <= rr_ptr_d;
            pre_q     <= pre_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            valve_q   <= valve_d;
            gid_q     <= gid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            pump_q    <= pump_d;
        end
    end

    // Request capture, round-robin pick and IDLE/RUN/GAP sequencing.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dur_d     = dur_q;
        rr_ptr_d  = rr_ptr_q;
        pre_d     = pre_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        valve_d   = valve_q;
        gid_d     = gid_q;
        done_d    = 1'b0;
        tick      = (pre_q == PRE_LAST);
        found     = 1'b0;
        pick      = rr_ptr_q;
        cand      = rr_ptr_q;

        // First pending zone at or after the round-robin pointer.
        for (int j = 0; j < 4; j++) begin
            cand = rr_ptr_q + 2'(j);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        // The zone currently running cannot queue a repeat of itself.
        for (int i = 0; i < 4; i++) begin
            if (req[i] && !abort && !(state_q == S_RUN && gid_q == 2'(i))) begin
                pending_d[i] = 1'b1;
                dur_d[i]     = long_sel[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found && !abort) begin
                    valve_d         = 4'b0001 << pick;
                    gid_d           = pick;
                    rem_d           = dur_q[pick] ? LEN_LONG : LEN_SHORT;
                    pending_d[pick] = 1'b0;
                    rr_ptr_d        = pick + 2'd1;
                    pre_d           = '0;
                    state_d         = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    valve_d = '0;
                    rem_d   = '0;
                    gap_d   = GAP_LEN;
                    pre_d   = '0;
                    state_d = S_GAP;
                end else begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        if (rem_q == 6'd1) begin
                            rem_d   = '0;
                            valve_d = '0;
                            done_d  = 1'b1;
                            gap_d   = GAP_LEN;
                            state_d = S_GAP;
                        end else begin
                            rem_d = rem_q - 6'd1;
                        end
                    end
                end
            end
            S_GAP: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (tick) begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == GW'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valve_d = '0;
            end
        endcase

        if (abort) begin
            pending_d = '0;
        end

        pump_d = (valve_d != 4'b0000);
        busy_d = (state_d != S_IDLE);
    end

    assign valve     = valve_q;
    assign pump_on   = pump_q;
    assign grant_id  = gid_q;
    assign remaining = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Bench for irrigation_zone_scheduler: directed scenarios plus random traffic,
// all compared against a timestamp-based reference model of the scheduler.
module tb_irrigation_zone_scheduler;

    localparam int TD = 4;
    localparam int RS = 3;
    localparam int RL = 6;
    localparam int GP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] long_sel = 4'b0;
    logic       abort = 1'b0;
    logic [3:0] valve;
    logic       pump_on;
    logic [1:0] grant_id;
    logic [5:0] remaining;
    logic       busy;
    logic       done;

    irrigation_zone_scheduler #(
        .TICK_DIV (TD),
        .RUN_SHORT(RS),
        .RUN_LONG (RL),
        .GAP_S    (GP)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .req      (req),
        .long_sel (long_sel),
        .abort    (abort),
        .valve    (valve),
        .pump_on  (pump_on),
        .grant_id (grant_id),
        .remaining(remaining),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phases with absolute edge timestamps.
    int         e_cnt = 0;
    int         m_phase = 0;      // 0 idle, 1 running, 2 settling
    logic [3:0] m_pend = 4'b0;
    logic [3:0] m_long = 4'b0;
    int         m_ptr = 0;
    int         m_zone = 0;
    int         m_start = 0;
    int         m_len_t = 0;
    int         m_gend = 0;
    logic [3:0] x_valve = 4'b0;
    logic       x_pump = 1'b0;
    logic [1:0] x_gid = 2'b0;
    logic [5:0] x_rem = 6'b0;
    logic       x_busy = 1'b0;
    logic       x_done = 1'b0;

    task automatic model_update();
        logic [3:0] old_pend;
        logic [3:0] old_long;
        bit         got;
        e_cnt++;
        x_done = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_pend  = 4'b0;
            m_long  = 4'b0;
            m_ptr   = 0;
            x_gid   = 2'b0;
        end else begin
            old_pend = m_pend;
            old_long = m_long;
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !abort && !(m_phase == 1 && m_zone == i)) begin
                    m_pend[i] = 1'b1;
                    m_long[i] = long_sel[i];
                end
            end
            case (m_phase)
                0: begin
                    if (!abort && old_pend != 4'b0) begin
                        got = 1'b0;
                        for (int j = 0; j < 4; j++) begin
                            int k;
                            k = (m_ptr + j) % 4;
                            if (!got && old_pend[k]) begin
                                got       = 1'b1;
                                m_zone    = k;
                                m_len_t   = old_long[k] ? RL : RS;
                                m_start   = e_cnt;
                                m_pend[k] = 1'b0;
                                m_ptr     = (k + 1) % 4;
                                x_gid     = 2'(k);
                                m_phase   = 1;
                            end
                        end
                    end
                end
                1: begin
                    if (abort) begin
                        m_phase = 2;
                        m_gend  = e_cnt + GP * TD;
                    end else if (e_cnt - m_start == m_len_t * TD) begin
                        m_phase = 2;
                        m_gend  = e_cnt + GP * TD;
                        x_done  = 1'b1;
                    end
                end
                default: begin
                    if (e_cnt == m_gend) m_phase = 0;
                end
            endcase
            if (abort) m_pend = 4'b0;
        end
        x_valve = (m_phase == 1) ? (4'b0001 << m_zone) : 4'b0;
        x_pump  = (m_phase == 1);
        x_busy  = (m_phase != 0);
        x_rem   = (m_phase == 1) ? 6'(m_len_t - (e_cnt - m_start) / TD) : 6'd0;
    endtask

    function automatic logic [14:0] obs_vec();
        return {valve, pump_on, grant_id, remaining, busy, done};
    endfunction

    function automatic logic [14:0] exp_vec();
        return {x_valve, x_pump, x_gid, x_rem, x_busy, x_done};
    endfunction

    function automatic int zone_of(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0; abort = 1'b0; long_sel = 4'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; long_sel = 4'h0; abort = 1'b0;
        step();
        n_checks++;
        if (obs_vec() !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", obs_vec());
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (valve !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_no_early_grant valve got=%b want=0000", valve);
        end
        req = 4'b0;
        step();
        n_checks++;
        if (valve !== 4'b0001 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_first_grant got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_short();
        int high = 0;
        int done_off = -1;
        int busy_off = -1;
        do_reset();
        req = 4'b0100; long_sel = 4'b0000;
        step();
        req = 4'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_vec off=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (valve === 4'b0100) high++;
            if (done === 1'b1) done_off = c;
            if (busy === 1'b0 && busy_off < 0) busy_off = c;
            if (c == 1 || c == 5 || c == 9 || c == 13) begin
                n_checks++;
                if (remaining !== 6'(RS - (c - 1) / TD)) begin
                    n_fail++;
                    $display("FAIL single_remaining off=%0d got=%0d want=%0d", c, remaining, RS - (c - 1) / TD);
                end
            end
        end
        n_checks++;
        if (high != RS * TD) begin
            n_fail++;
            $display("FAIL single_open_cycles got=%0d want=%0d", high, RS * TD);
        end
        n_checks++;
        if (done_off != RS * TD + 1) begin
            n_fail++;
            $display("FAIL single_done_offset got=%0d want=%0d", done_off, RS * TD + 1);
        end
        n_checks++;
        if (busy_off != RS * TD + 1 + GP * TD) begin
            n_fail++;
            $display("FAIL single_busy_end got=%0d want=%0d", busy_off, RS * TD + 1 + GP * TD);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int rises[$];
        int falls[$];
        int lens[$];
        int exp_order[4] = '{0, 1, 3, 0};
        int exp_len[4]   = '{RS * TD, RL * TD, RL * TD, RS * TD};
        logic [3:0] pv = 4'b0;
        bit posted = 1'b0;
        do_reset();
        req = 4'b1011; long_sel = 4'b1010;
        step();
        req = 4'b0; long_sel = 4'b0;
        for (int c = 0; c < 130; c++) begin
            if (!posted && order.size() == 3) begin
                req = 4'b0001; posted = 1'b1;
            end else begin
                req = 4'b0;
            end
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_vec edge=%0d got=%h want=%h", e_cnt, obs_vec(), exp_vec());
            end
            if (valve != 4'b0 && pv == 4'b0) begin
                order.push_back(zone_of(valve));
                rises.push_back(e_cnt);
            end
            if (valve == 4'b0 && pv != 4'b0 && rises.size() > 0) begin
                falls.push_back(e_cnt);
                lens.push_back(e_cnt - rises[rises.size() - 1]);
            end
            pv = valve;
        end
        req = 4'b0;
        n_checks++;
        if (order.size() != 4 || lens.size() != 4) begin
            n_fail++;
            $display("FAIL rr_grant_count got=%0d/%0d want=4/4", order.size(), lens.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], exp_order[i]);
                end
                n_checks++;
                if (lens[i] != exp_len[i]) begin
                    n_fail++;
                    $display("FAIL rr_len idx=%0d got=%0d want=%0d", i, lens[i], exp_len[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (rises[i + 1] - falls[i] != GP * TD + 1) begin
                    n_fail++;
                    $display("FAIL rr_spacing idx=%0d got=%0d want=%0d", i, rises[i + 1] - falls[i], GP * TD + 1);
                end
            end
        end
    endtask

    task automatic test_abort();
        bit saw_done = 1'b0;
        bit late_valve = 1'b0;
        int bfall = -1;
        do_reset();
        req = 4'b0010; long_sel = 4'b0010;
        step();
        req = 4'b0; long_sel = 4'b0;
        for (int c = 1; c <= 40; c++) begin
            req   = (c == 3) ? 4'b1000 : 4'b0000;
            abort = (c == 9);
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL abort_vec off=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (done === 1'b1) saw_done = 1'b1;
            if (c > 9 && valve !== 4'b0) late_valve = 1'b1;
            if (c > 1 && busy === 1'b0 && bfall < 0) bfall = c;
            if (c == 8) begin
                n_checks++;
                if (valve !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL abort_pre_valve got=%b want=0010", valve);
                end
            end
            if (c == 9) begin
                n_checks++;
                if (valve !== 4'b0 || remaining !== 6'd0 || busy !== 1'b1 || pump_on !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_stop got=%h want valve=0 rem=0 busy=1 pump=0", obs_vec());
                end
            end
        end
        req = 4'b0; abort = 1'b0;
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL abort_no_done got=1 want=0");
        end
        n_checks++;
        if (late_valve) begin
            n_fail++;
            $display("FAIL abort_flush got=regrant want=none");
        end
        n_checks++;
        if (bfall != 9 + GP * TD) begin
            n_fail++;
            $display("FAIL abort_gap_end got=%0d want=%0d", bfall, 9 + GP * TD);
        end
    endtask

    task automatic test_conflicts();
        bit bad = 1'b0;
        int order[$];
        int rises[$];
        int lens[$];
        logic [3:0] pv = 4'b0;
        do_reset();
        req = 4'b0001; abort = 1'b1;
        step();
        req = 4'b0; abort = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (valve !== 4'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL conflict_abort_req got=grant want=none");
        end
        req = 4'b0100; long_sel = 4'b0;
        step();
        for (int c = 1; c <= 80; c++) begin
            req      = (c == 4) ? 4'b0110 : (c == 6) ? 4'b0010 : 4'b0000;
            long_sel = (c == 6) ? 4'b0010 : 4'b0000;
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL conflict_vec off=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (valve != 4'b0 && pv == 4'b0) begin
                order.push_back(zone_of(valve));
                rises.push_back(e_cnt);
            end
            if (valve == 4'b0 && pv != 4'b0 && rises.size() > 0) lens.push_back(e_cnt - rises[rises.size() - 1]);
            pv = valve;
        end
        req = 4'b0; long_sel = 4'b0;
        n_checks++;
        if (order.size() != 2 || lens.size() != 2) begin
            n_fail++;
            $display("FAIL conflict_grants got=%0d want=2", order.size());
        end else begin
            n_checks++;
            if (order[0] != 2 || order[1] != 1) begin
                n_fail++;
                $display("FAIL conflict_order got=%0d,%0d want=2,1", order[0], order[1]);
            end
            n_checks++;
            if (lens[1] != RL * TD) begin
                n_fail++;
                $display("FAIL conflict_new_duration got=%0d want=%0d", lens[1], RL * TD);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit bad = 1'b0;
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0;
        repeat (6) step();
        n_checks++;
        if (valve !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrun_running got=%b want=0001", valve);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (obs_vec() !== 15'd0) begin
            n_fail++;
            $display("FAIL midrun_reset got=%h want=0", obs_vec());
        end
        for (int c = 0; c < 20; c++) begin
            step();
            if (valve !== 4'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL midrun_idle_after got=activity want=idle");
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(799) == 0);
            abort    = ($urandom_range(59) == 0);
            req      = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0;
            long_sel = 4'($urandom);
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_vec edge=%0d got=%h want=%h", e_cnt, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0; abort = 1'b0; req = 4'b0; long_sel = 4'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout reached got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_short();
        test_round_robin();
        test_abort();
        test_conflicts();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
